// File: rtl/hilo_pkg.sv
// Shared types and widths for the HI/LO multicycle register file.
package hilo_pkg;

  localparam int unsigned HILO_W     = 32;
  localparam int unsigned HILO_LANES = 2;
  localparam int unsigned HILO_RES_W = 2 * HILO_W;

  // md op tracker states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } hilo_state_e;

  // One commit lane's HI/LO request
  typedef struct packed {
    logic              rd_hi;
    logic              rd_lo;
    logic              wr_hi;
    logic              wr_lo;
    logic [HILO_W-1:0] data;
  } hilo_lane_t;

  // md unit result payload
  typedef struct packed {
    logic [HILO_W-1:0] hi;
    logic [HILO_W-1:0] lo;
  } hilo_md_res_t;

  // True when a lane touches HI or LO in any way
  function automatic logic lane_access(input hilo_lane_t l);
    return l.rd_hi | l.rd_lo | l.wr_hi | l.wr_lo;
  endfunction

endpackage

// File: rtl/hilo_bypass_net.sv
// Per-lane forwarding chain: each lane sees the base value updated by all
// older lanes' writes; the end of the chain is the next HI/LO state.
module hilo_bypass_net
  import hilo_pkg::*;
#(
  parameter int unsigned N_LANES = HILO_LANES
) (
  input  logic [HILO_W-1:0] base_hi,
  input  logic [HILO_W-1:0] base_lo,
  input  hilo_lane_t        lanes   [N_LANES],
  input  logic              lane_en,
  output logic [HILO_W-1:0] rd_data [N_LANES],
  output logic [HILO_W-1:0] next_hi,
  output logic [HILO_W-1:0] next_lo
);

  logic [HILO_W-1:0] cur_hi;
  logic [HILO_W-1:0] cur_lo;

  // Walk lanes oldest to youngest; a lane reads before applying its own write
  always_comb begin
    cur_hi = base_hi;
    cur_lo = base_lo;
    for (int k = 0; k < int'(N_LANES); k++) begin
      rd_data[k] = '0;
      if (lanes[k].rd_hi) begin
        rd_data[k] = cur_hi;
      end else if (lanes[k].rd_lo) begin
        rd_data[k] = cur_lo;
      end
      if (lane_en && lanes[k].wr_hi) begin
        cur_hi = lanes[k].data;
      end
      if (lane_en && lanes[k].wr_lo) begin
        cur_lo = lanes[k].data;
      end
    end
    next_hi = cur_hi;
    next_lo = cur_lo;
  end

endmodule

// File: rtl/hilo_mc_regfile.sv
// Multi-lane HI/LO register file with in-flight tracking of the external
// multicycle mult/div unit (stall while pending, discard flushed results).
module hilo_mc_regfile
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_W  = HILO_W,
  parameter int unsigned N_LANES = HILO_LANES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic                      md_start_i,
  input  logic                      md_done_i,
  input  logic [2*DATA_W-1:0]       md_result_i,
  input  logic [N_LANES-1:0]        rd_hi_i,
  input  logic [N_LANES-1:0]        rd_lo_i,
  input  logic [N_LANES-1:0]        wr_hi_i,
  input  logic [N_LANES-1:0]        wr_lo_i,
  input  logic [N_LANES*DATA_W-1:0] wr_data_i,
  output logic [N_LANES*DATA_W-1:0] rd_data_o,
  output logic                      stall_o,
  output logic                      md_busy_o,
  output logic [DATA_W-1:0]         hi_o,
  output logic [DATA_W-1:0]         lo_o
);

  hilo_state_e       state;
  hilo_lane_t        lanes    [N_LANES];
  logic [HILO_W-1:0] lane_rd  [N_LANES];
  hilo_md_res_t      md_res;
  logic [HILO_W-1:0] hi_q;
  logic [HILO_W-1:0] lo_q;
  logic [HILO_W-1:0] base_hi;
  logic [HILO_W-1:0] base_lo;
  logic [HILO_W-1:0] next_hi;
  logic [HILO_W-1:0] next_lo;
  logic              access_c;
  logic              md_acc_c;
  logic              start_acc_c;

  assign md_res = HILO_RES_W'(md_result_i);

  // Unpack flat lane ports into lane records and detect any HI/LO access
  always_comb begin
    access_c = md_start_i;
    for (int k = 0; k < int'(N_LANES); k++) begin
      lanes[k].rd_hi = rd_hi_i[k];
      lanes[k].rd_lo = rd_lo_i[k];
      lanes[k].wr_hi = wr_hi_i[k];
      lanes[k].wr_lo = wr_lo_i[k];
      lanes[k].data  = HILO_W'(wr_data_i[k*DATA_W +: DATA_W]);
      access_c       = access_c | lane_access(lanes[k]);
    end
  end

  // Hold the bundle while a result is owed and not arriving, or while draining
  assign stall_o = access_c & (((state == BUSY) & ~md_done_i) | (state == DRAIN));

  // A result is committed only when it belongs to a live (unflushed) op
  assign md_acc_c    = (state == BUSY) & md_done_i & ~flush_i;
  assign start_acc_c = md_start_i & ~flush_i & ~stall_o;

  // md result is older than every lane of the bundle
  assign base_hi = md_acc_c ? md_res.hi : hi_q;
  assign base_lo = md_acc_c ? md_res.lo : lo_q;

  hilo_bypass_net #(
    .N_LANES (N_LANES)
  ) u_bypass (
    .base_hi (base_hi),
    .base_lo (base_lo),
    .lanes   (lanes),
    .lane_en (~stall_o),
    .rd_data (lane_rd),
    .next_hi (next_hi),
    .next_lo (next_lo)
  );

  // Repack per-lane read data onto the flat output bus
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < int'(N_LANES); k++) begin
      rd_data_o[k*DATA_W +: DATA_W] = DATA_W'(lane_rd[k]);
    end
  end

  // Architectural HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= next_hi;
      lo_q <= next_lo;
    end
  end

  assign hi_o = DATA_W'(hi_q);
  assign lo_o = DATA_W'(lo_q);

  // md op tracker with registered busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      md_busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_acc_c) begin
            state     <= BUSY;
            md_busy_o <= 1'b1;
          end
        end
        BUSY: begin
          if (flush_i) begin
            if (md_done_i) begin
              state     <= IDLE;
              md_busy_o <= 1'b0;
            end else begin
              state     <= DRAIN;
              md_busy_o <= 1'b1;
            end
          end else if (md_done_i && !start_acc_c) begin
            state     <= IDLE;
            md_busy_o <= 1'b0;
          end
        end
        DRAIN: begin
          if (md_done_i) begin
            state     <= IDLE;
            md_busy_o <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          md_busy_o <= 1'b0;
        end
      endcase
    end
  end

  // A done pulse with nothing in flight is a protocol violation by the md unit
  md_done_in_idle_a: assert property (@(posedge clk) disable iff (reset)
    !((state == IDLE) && md_done_i))
    else $warning("hilo_mc_regfile: md_done_i while idle, ignored");

endmodule
